// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter: arbitrates four requesters onto one shared FP adder, one operation in flight.
// Optional macro ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
`default_nettype none

module fp_adder_arbiter #(
    parameter int DATA_W  = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]        rsp_ack,
    output logic                      add_load,
    output logic [DATA_W-1:0]         add_a,
    output logic [DATA_W-1:0]         add_b,
    input  logic [DATA_W-1:0]         add_result,
    input  logic                      add_ready,
    output logic                      add_ack,
    output logic                      busy,
    output logic [1:0]                owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          owner_q, owner_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  vld_q, vld_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                load_q, load_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;

    logic [1:0]          win;
    logic                win_vld;
    logic [1:0]          idx;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // First set request at or after the pointer wins; the 2-bit add wraps 3->0.
    always_comb begin
        win     = ptr_q;
        win_vld = 1'b0;
        idx     = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr_q + 2'(k);
            if (!win_vld && req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = '0;
        vld_d   = vld_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        load_d  = 1'b0;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    a_d     = req_a[DATA_W*int'(win) +: DATA_W];
                    b_d     = req_b[DATA_W*int'(win) +: DATA_W];
                    owner_d = win;
                    gnt_d   = onehot(win);
                    load_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (add_ready) begin
                    data_d  = add_result;
                    vld_d   = onehot(owner_q);
                    ack_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ack[owner_q]) begin
                    vld_d   = '0;
`ifdef ARB_FIXED_PRIO_EN
                    ptr_d   = 2'd0;
`else
                    ptr_d   = owner_q + 2'd1;
`endif
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            gnt_q   <= '0;
            vld_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            load_q  <= load_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign req_gnt   = gnt_q;
    assign rsp_valid = vld_q;
    assign rsp_data  = data_q;
    assign add_load  = load_q;
    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_ack   = ack_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_adder_arbiter.sv
// tb_fp_adder_arbiter: directed scoreboard bench with a behavioural 4-cycle FP adder.
// Expectations follow ARB_FIXED_PRIO_EN when it is defined.
`default_nettype none

module tb_fp_adder_arbiter;

    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [NUM_REQ-1:0]        rsp_ack;
    logic                      add_load;
    logic [DATA_W-1:0]         add_a;
    logic [DATA_W-1:0]         add_b;
    logic [DATA_W-1:0]         add_result;
    logic                      add_ready;
    logic                      add_ack;
    logic                      busy;
    logic [1:0]                owner;

    always #5 clk = ~clk;

    fp_adder_arbiter #(.DATA_W(DATA_W), .NUM_REQ(NUM_REQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_gnt    (req_gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_ack    (rsp_ack),
        .add_load   (add_load),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .add_ready  (add_ready),
        .add_ack    (add_ack),
        .busy       (busy),
        .owner      (owner)
    );

    typedef struct packed {
        logic [3:0]  oh;
        logic [31:0] a;
        logic [31:0] b;
    } gnt_t;

    typedef struct packed {
        logic [3:0]  vld;
        logic [31:0] data;
    } rsp_t;

    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int gnt_seen  = 0;
    int rsp_seen  = 0;
    int ack_seen  = 0;
    int rsp_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_gnt(input logic [3:0] oh, input logic [31:0] a, input logic [31:0] b);
        gnt_t g;
        g.oh = oh;
        g.a  = a;
        g.b  = b;
        exp_gnt.push_back(g);
    endtask

    task automatic push_rsp(input logic [3:0] vld, input logic [31:0] data);
        rsp_t r;
        r.vld  = vld;
        r.data = data;
        exp_rsp.push_back(r);
        rsp_total++;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    // Hand-computed IEEE-754 single sums for the operand pairs used below.
    function automatic logic [31:0] sum_of(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: sum_of = 32'h40400000;
            {32'h3F800000, 32'h3F800000}: sum_of = 32'h40000000;
            {32'h40000000, 32'h40000000}: sum_of = 32'h40800000;
            {32'h3F000000, 32'h3F000000}: sum_of = 32'h3F800000;
            {32'h3FC00000, 32'h40200000}: sum_of = 32'h40800000;
            default:                      sum_of = 32'hDEADBEEF;
        endcase
    endfunction

    // Shared adder: load seen in cycle T+1 gives result_ready in T+4, held until acked.
    initial begin
        int          cnt;
        logic [31:0] la;
        logic [31:0] lb;
        cnt        = 0;
        la         = '0;
        lb         = '0;
        add_ready  = 1'b0;
        add_result = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cnt       = 0;
                add_ready = 1'b0;
            end else begin
                if (add_ready && add_ack) add_ready = 1'b0;
                if (add_load) begin
                    la  = add_a;
                    lb  = add_b;
                    cnt = 3;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        add_ready  = 1'b1;
                        add_result = sum_of(la, lb);
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every grant pulse and every rising response.
    initial begin
        logic [3:0] prev_vld;
        gnt_t       g;
        rsp_t       r;
        prev_vld = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("load_only_with_gnt", 32'(add_load), 32'(req_gnt != 4'b0));
                if (req_gnt != 4'b0) begin
                    gnt_seen++;
                    if (exp_gnt.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_gnt: got %b expected none", req_gnt);
                    end else begin
                        g = exp_gnt.pop_front();
                        check("gnt_onehot", 32'(req_gnt), 32'(g.oh));
                        check("gnt_add_a", add_a, g.a);
                        check("gnt_add_b", add_b, g.b);
                    end
                end
                if (rsp_valid != 4'b0 && prev_vld == 4'b0) begin
                    rsp_seen++;
                    if (exp_rsp.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got %b expected none", rsp_valid);
                    end else begin
                        r = exp_rsp.pop_front();
                        check("rsp_valid", 32'(rsp_valid), 32'(r.vld));
                        check("rsp_data", rsp_data, r.data);
                    end
                end
                if (add_ack) ack_seen++;
                prev_vld = rsp_valid;
            end else begin
                prev_vld = '0;
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_gnt(input int target);
        for (int i = 0; i < 200 && gnt_seen < target; i++) begin
            @(negedge clk);
            #1;
        end
        check("wait_gnt_bound", 32'(gnt_seen >= target), 32'd1);
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 200 && rsp_seen < target; i++) begin
            @(negedge clk);
            #1;
        end
        check("wait_rsp_bound", 32'(rsp_seen >= target), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && (busy || exp_gnt.size() != 0 || exp_rsp.size() != 0); i++) begin
            @(negedge clk);
            #1;
        end
        check("wait_idle_bound", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'(req_gnt),   32'd0);
        check({tag, "_vld"},   32'(rsp_valid), 32'd0);
        check({tag, "_data"},  rsp_data,       32'd0);
        check({tag, "_load"},  32'(add_load),  32'd0);
        check({tag, "_ack"},   32'(add_ack),   32'd0);
        check({tag, "_a"},     add_a,          32'd0);
        check({tag, "_b"},     add_b,          32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_owner"}, 32'(owner),     32'd0);
    endtask

    initial begin
        int base;
        reset   = 1'b0;
        req     = '0;
        rsp_ack = '0;
        req_a   = '0;
        req_b   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single operation, immediate ack, cycle-exact latency.
        set_ops(0, 32'h3F800000, 32'h40000000);
        rsp_ack = 4'b1111;
        push_gnt(4'b0001, 32'h3F800000, 32'h40000000);
        push_rsp(4'b0001, 32'h40400000);
        @(posedge clk);
        #1;
        req = 4'b0001;
        @(negedge clk);
        check("t0_no_gnt", 32'(req_gnt), 32'd0);
        @(negedge clk);
        check("t1_gnt", 32'(req_gnt), 32'b0001);
        check("t1_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        check("t4_no_vld", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("t5_vld", 32'(rsp_valid), 32'b0001);
        check("t5_data", rsp_data, 32'h40400000);
        check("t5_ack", 32'(add_ack), 32'd1);
        @(negedge clk);
        check("t6_idle", 32'(busy), 32'd0);
        check("t6_ack", 32'(add_ack), 32'd0);
        wait_idle();

        // All four requesting, acks immediate.
        do_reset();
        set_ops(0, 32'h3F800000, 32'h40000000);
        set_ops(1, 32'h3F800000, 32'h3F800000);
        set_ops(2, 32'h40000000, 32'h40000000);
        set_ops(3, 32'h3F000000, 32'h3F000000);
        base = gnt_seen;
`ifdef ARB_FIXED_PRIO_EN
        for (int k = 0; k < 3; k++) begin
            push_gnt(4'b0001, 32'h3F800000, 32'h40000000);
            push_rsp(4'b0001, 32'h40400000);
        end
`else
        push_gnt(4'b0001, 32'h3F800000, 32'h40000000);
        push_rsp(4'b0001, 32'h40400000);
        push_gnt(4'b0010, 32'h3F800000, 32'h3F800000);
        push_rsp(4'b0010, 32'h40000000);
        push_gnt(4'b0100, 32'h40000000, 32'h40000000);
        push_rsp(4'b0100, 32'h40800000);
        push_gnt(4'b1000, 32'h3F000000, 32'h3F000000);
        push_rsp(4'b1000, 32'h3F800000);
        push_gnt(4'b0001, 32'h3F800000, 32'h40000000);
        push_rsp(4'b0001, 32'h40400000);
`endif
        @(posedge clk);
        #1;
        req = 4'b1111;
`ifdef ARB_FIXED_PRIO_EN
        wait_gnt(base + 3);
`else
        wait_gnt(base + 5);
`endif
        req = 4'b0000;
        wait_idle();

        // Withheld ack: response held, no new grant, requester re-served afterwards.
        rsp_ack = 4'b0000;
        base    = rsp_seen;
        push_gnt(4'b0100, 32'h40000000, 32'h40000000);
        push_rsp(4'b0100, 32'h40800000);
        push_gnt(4'b0100, 32'h40000000, 32'h40000000);
        push_rsp(4'b0100, 32'h40800000);
        @(posedge clk);
        #1;
        req = 4'b0100;
        wait_rsp(base + 1);
        base = gnt_seen;
        for (int i = 0; i < 10; i++) begin
            check("hold_vld",  32'(rsp_valid), 32'b0100);
            check("hold_busy", 32'(busy),      32'd1);
            check("hold_gnt",  32'(req_gnt),   32'd0);
            @(negedge clk);
            #1;
        end
        rsp_ack = 4'b0100;
        wait_gnt(base + 1);
        req = 4'b0000;
        wait_idle();

        // Request dropped and operands changed right after the grant.
        rsp_ack = 4'b1111;
        set_ops(2, 32'h3FC00000, 32'h40200000);
        push_gnt(4'b0100, 32'h3FC00000, 32'h40200000);
        push_rsp(4'b0100, 32'h40800000);
        base = gnt_seen;
        @(posedge clk);
        #1;
        req = 4'b0100;
        wait_gnt(base + 1);
        req = 4'b0000;
        set_ops(2, 32'h00000000, 32'h00000000);
        wait_idle();

        // Reset while waiting on the adder, then service resumes from pointer 0.
        set_ops(3, 32'h3F000000, 32'h3F000000);
        push_gnt(4'b1000, 32'h3F000000, 32'h3F000000);
        base = gnt_seen;
        @(posedge clk);
        #1;
        req = 4'b1000;
        wait_gnt(base + 1);
        req = 4'b0000;
        @(negedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        #1;
        reset = 1'b1;
        set_ops(1, 32'h3F800000, 32'h3F800000);
        push_gnt(4'b0010, 32'h3F800000, 32'h3F800000);
        push_rsp(4'b0010, 32'h40000000);
        push_gnt(4'b1000, 32'h3F000000, 32'h3F000000);
        push_rsp(4'b1000, 32'h3F800000);
        base = gnt_seen;
        @(posedge clk);
        #1;
        req = 4'b1010;
        wait_gnt(base + 1);
        req = 4'b1000;
        wait_gnt(base + 2);
        req = 4'b0000;
        wait_idle();

        repeat (3) @(negedge clk);
        check("gnt_queue_empty", 32'(exp_gnt.size()), 32'd0);
        check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
        check("rsp_count", 32'(rsp_seen), 32'(rsp_total));
        check("ack_pulses", 32'(ack_seen), 32'(rsp_total));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
